// File: rtl/register.sv
`default_nettype none
// ============================================================================
//  Module      : register
//  Description : Program-counter state register for the RISC-V core. Captures
//                the selected next-PC on each rising clock edge and presents
//                it as the current PC to instruction fetch and the PC adder.
//                Pure storage: next-PC selection is done upstream.
//
//  Parameters  : WIDTH        - PC width in bits
//                RESET_VALUE  - boot address loaded while rst_n is low
//
//  Ports       : clk     in   1      system clock, rising-edge active
//                rst_n   in   1      asynchronous active-low reset
//                en      in   1      load enable (0 = stall, PC holds)
//                PC_in   in   WIDTH  next-PC value to capture
//                PC_out  out  WIDTH  current PC, registered
//
//  Revision    : 1.0  initial release
// ============================================================================
module register #(
    parameter int unsigned      WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] PC_in,
    output logic [WIDTH-1:0] PC_out
);

    logic [WIDTH-1:0] r_pc;

    // The reset branch has priority, so a falling rst_n coincident with a
    // rising clk always lands on RESET_VALUE. All WIDTH bits are stored
    // verbatim; misaligned PCs are not masked here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_VALUE;
        end else if (en) begin
            r_pc <= PC_in;
        end
    end

    // Output comes straight from the flops: no path from PC_in or en.
    assign PC_out = r_pc;

endmodule
`default_nettype wire

// File: tb/tb_register.sv
`default_nettype none
// ============================================================================
//  Module      : tb_register
//  Description : Self-checking bench for the PC register. Two instances share
//                stimulus: one with the default boot address 0, one with boot
//                address 0x8000_0000. A behavioural model tracks the expected
//                PC of each instance from the documented rules.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_register;

    localparam int unsigned  c_WIDTH = 32;
    localparam logic [31:0]  c_RV0   = 32'h0000_0000;
    localparam logic [31:0]  c_RV1   = 32'h8000_0000;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [31:0] pc_in;
    logic [31:0] pc_out0;
    logic [31:0] pc_out1;

    // Reference model state: expected PC of each instance.
    logic [31:0] exp0;
    logic [31:0] exp1;

    int n_tests;
    int n_fail;

    register #(
        .WIDTH       (c_WIDTH),
        .RESET_VALUE (c_RV0)
    ) u_dut0 (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .PC_in  (pc_in),
        .PC_out (pc_out0)
    );

    register #(
        .WIDTH       (c_WIDTH),
        .RESET_VALUE (c_RV1)
    ) u_dut1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .PC_in  (pc_in),
        .PC_out (pc_out1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, expv, $time);
        end
    endtask

    task automatic check_both(input string tag);
        check({tag, "/rv0"}, pc_out0, exp0);
        check({tag, "/rv1"}, pc_out1, exp1);
    endtask

    // One full clock cycle: low phase, rising edge, sample 1 ns later,
    // remainder of high phase, falling edge. The model applies the load
    // rule as of the rising edge.
    task automatic cycle(input string tag);
        #5;
        if (rst_n && en) begin
            exp0 = pc_in;
            exp1 = pc_in;
        end
        clk = 1'b1;
        #1;
        check_both(tag);
        #4;
        clk = 1'b0;
    endtask

    // Asynchronous reset assertion: effective immediately, no clock needed.
    task automatic assert_reset(input string tag);
        rst_n = 1'b0;
        exp0  = c_RV0;
        exp1  = c_RV1;
        #1;
        check_both(tag);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        clk     = 1'b0;
        rst_n   = 1'b1;
        en      = 1'b1;
        pc_in   = 32'h0000_00FF;
        exp0    = 32'h0;
        exp1    = 32'h0;
        #2;

        // Reset held with clock toggling: PC pinned at the boot address.
        assert_reset("reset_assert");
        for (int i = 0; i < 3; i++) cycle("reset_hold");

        // Release without an edge leaves the PC alone.
        #2;
        rst_n = 1'b1;
        #2;
        check_both("reset_release");

        // Clock held low 100 ns, then a single edge loads PC_in.
        #100;
        cycle("load_ff");
        pc_in = 32'h0000_00AF;
        cycle("load_af");

        // Input change while clk low does not propagate.
        #1;
        pc_in = 32'h0000_00FA;
        #2;
        check_both("hold_low");
        cycle("load_fa");

        // Input change while clk high does not propagate.
        #5;
        clk = 1'b1;
        #1;
        pc_in = 32'h0000_0055;
        #2;
        check_both("hold_high");
        #2;
        clk = 1'b0;
        pc_in = 32'h0000_00FA;
        cycle("reload_fa");

        // Stall: two edges with en low, then one edge with en high.
        en    = 1'b0;
        pc_in = 32'h1234_5678;
        cycle("stall_1");
        cycle("stall_2");
        en = 1'b1;
        cycle("unstall");

        // Async reset between edges overrides the pending load.
        pc_in = 32'h0000_00FA;
        cycle("pre_async");
        pc_in = 32'hDEAD_BEEC;
        #2;
        assert_reset("async_mid");
        cycle("async_hold");
        rst_n = 1'b1;
        #1;
        check_both("async_release");

        // Full-width and misaligned values stored verbatim.
        pc_in = 32'hFFFF_FFFF;
        cycle("full_ones");
        pc_in = 32'h0000_0003;
        cycle("misaligned");

        // Reset falling at the same instant as the rising clock: reset wins.
        pc_in = 32'hCAFE_F00D;
        #5;
        rst_n = 1'b0;
        clk   = 1'b1;
        exp0  = c_RV0;
        exp1  = c_RV1;
        #1;
        check_both("rst_clk_race");
        #4;
        clk = 1'b0;
        #2;
        rst_n = 1'b1;

        // Randomized traffic with occasional mid-cycle resets and
        // between-edge input glitches.
        for (int i = 0; i < 300; i++) begin
            en    = ($urandom_range(0, 3) != 0);
            pc_in = $urandom;
            if ($urandom_range(0, 19) == 0) begin
                assert_reset("rand_reset");
                if ($urandom_range(0, 1) == 1) cycle("rand_reset_edge");
                rst_n = 1'b1;
                #1;
                check_both("rand_release");
            end
            cycle("rand_edge");
            // Glitch the inputs after the edge; output must not follow.
            pc_in = $urandom;
            en    = $urandom_range(0, 1) == 1;
            #1;
            check_both("rand_glitch");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
